lsu_mem_initiator: RTL and testbench



---
 rtl/lsu_pkg.sv | 15 +
 rtl/lsu_align.sv | 29 ++
 rtl/lsu_mem_initiator.sv | 133 +++++++++++++
 tb/tb_lsu_mem_initiator.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and lane-datapath width shared by the LSU memory initiator.
// `LSU_MISALIGN_EN selects a 64-bit (two-word) lane datapath; otherwise it is one word wide.
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_ILL = 2'd3;
`ifdef LSU_MISALIGN_EN
  localparam int LW = 64;
`else
  localparam int LW = 32;
`endif
  localparam int MW = LW / 8;
  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane alignment: store strobes/data and extended load data.
// Ports: off_i byte offset, size_i access size, uns_i zero-extend, wdata_i right-aligned store data,
// rdata_i captured words {hi,lo} (lo only without `LSU_MISALIGN_EN), mask_o strobes, sdata_o lane data,
// ldata_o extended load result.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]    off_i,
  input  logic [1:0]    size_i,
  input  logic          uns_i,
  input  logic [31:0]   wdata_i,
  input  logic [LW-1:0] rdata_i,
  output logic [MW-1:0] mask_o,
  output logic [LW-1:0] sdata_o,
  output logic [31:0]   ldata_o
);
  logic [3:0]  base;
  logic [5:0]  sh;
  logic [31:0] raw;
  always_comb begin
    base = size_i == SZ_B ? 4'h1 : size_i == SZ_H ? 4'h3 : 4'hF;
    sh = {1'b0, off_i, 3'b000};
    mask_o = MW'({4'b0000, base} << off_i);
    sdata_o = LW'({32'b0, wdata_i} << sh);
    raw = 32'(rdata_i >> sh);
    ldata_o = size_i == SZ_B ? {{24{~uns_i & raw[7]}}, raw[7:0]} :
              size_i == SZ_H ? {{16{~uns_i & raw[15]}}, raw[15:0]} : raw;
  end
endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: LSU byte/half/word requests to word-aligned memory accesses with strobes and extension.
// Ports: clock/reset (sync, active-high); req_* request handshake; resp_* response handshake;
// mem_* data-side memory port (mem_rdata combinational). `LSU_MISALIGN_EN enables word-crossing splits.
module lsu_mem_initiator
  import lsu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);
  state_t state_q, state_d;
  logic wr_q, uns_q, err_q, illegal;
  logic [1:0] size_q;
  logic [31:0] addr_q, wdata_q, lo_q, ldata;
  logic [MW-1:0] mask;
  logic [LW-1:0] sdata;
`ifdef LSU_MISALIGN_EN
  logic [31:0] hi_q;
  logic cross;
  assign illegal = req_size == SZ_ILL;
  assign cross = ({1'b0, addr_q[1:0]} + (3'd1 << size_q)) > 3'd4;
`else
  assign illegal = req_size == SZ_ILL || (req_size == SZ_H && req_addr[0]) ||
                   (req_size == SZ_W && req_addr[1:0] != 2'b00);
`endif
  lsu_align u_align (
    .off_i(addr_q[1:0]),
    .size_i(size_q),
    .uns_i(uns_q),
    .wdata_i(wdata_q),
`ifdef LSU_MISALIGN_EN
    .rdata_i({hi_q, lo_q}),
`else
    .rdata_i(lo_q),
`endif
    .mask_o(mask),
    .sdata_o(sdata),
    .ldata_o(ldata)
  );
  assign resp_err = state_q == RESP && err_q;
  assign resp_rdata = state_q == RESP && !err_q && !wr_q ? ldata : 32'b0;
  always_ff @(posedge clock) state_q <= reset ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    mem_en = 1'b0;
    mem_wr = 1'b0;
    mem_addr = 32'b0;
    mem_wdata = 32'b0;
    mem_wstrb = 4'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = illegal ? RESP : LO;
      end
      LO: begin
        mem_en = 1'b1;
        mem_wr = wr_q;
        mem_addr = {addr_q[31:2], 2'b00};
        mem_wdata = sdata[31:0];
        mem_wstrb = wr_q ? mask[3:0] : 4'b0;
`ifdef LSU_MISALIGN_EN
        state_d = cross ? HI : RESP;
`else
        state_d = RESP;
`endif
      end
`ifdef LSU_MISALIGN_EN
      HI: begin
        mem_en = 1'b1;
        mem_wr = wr_q;
        mem_addr = {addr_q[31:2], 2'b00} + 32'd4;
        mem_wdata = sdata[63:32];
        mem_wstrb = wr_q ? mask[7:4] : 4'b0;
        state_d = RESP;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= 1'b0;
      uns_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'b0;
      addr_q <= 32'b0;
      wdata_q <= 32'b0;
      lo_q <= 32'b0;
`ifdef LSU_MISALIGN_EN
      hi_q <= 32'b0;
`endif
    end else if (state_q == IDLE && req_valid) begin
      wr_q <= req_wr;
      uns_q <= req_unsigned;
      err_q <= illegal;
      size_q <= req_size;
      addr_q <= req_addr;
      wdata_q <= req_wdata;
      lo_q <= 32'b0;
`ifdef LSU_MISALIGN_EN
      hi_q <= 32'b0;
`endif
    end else if (state_q == LO) begin
      lo_q <= mem_rdata;
`ifdef LSU_MISALIGN_EN
    end else if (state_q == HI) begin
      hi_q <= mem_rdata;
`endif
    end
  end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed self-checking bench for lsu_mem_initiator against a word memory model.
module tb_lsu_mem_initiator;
  logic clock = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, req_wr = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0] req_size = '0;
  logic resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;
  logic mem_en, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  logic [31:0] mem [0:16383];
  int checks = 0, errors = 0;
  int mon_total = 0;
  logic [31:0] mon_addr [0:15];
  logic [31:0] mon_wdata [0:15];
  logic [3:0] mon_wstrb [0:15];
  logic mon_wr [0:15];
  int base, lat;

  lsu_mem_initiator dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;
  assign mem_rdata = mem[mem_addr[15:2]];

  always @(posedge clock)
    if (mem_en && mem_wr)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

  always @(negedge clock)
    if (mem_en) begin
      mon_addr[mon_total[3:0]] <= mem_addr;
      mon_wdata[mon_total[3:0]] <= mem_wdata;
      mon_wstrb[mon_total[3:0]] <= mem_wstrb;
      mon_wr[mon_total[3:0]] <= mem_wr;
      mon_total <= mon_total + 1;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd);
    @(negedge clock);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    base = mon_total;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_size = sz; req_unsigned = uns; req_wdata = wd;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!resp_valid && lat < 10);
  endtask

  task automatic consume();
    @(negedge clock);
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    chk("resp_valid_dropped", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    mem[14'h0800] = 32'h0000F080;
    mem[14'h0C00] = 32'h44332211;
    mem[14'h0C01] = 32'h88776655;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    reset = 1'b0;

    do_req(1'b1, 32'h1003, 2'd0, 1'b0, 32'h000000A5);
    chk("sb_latency", lat, 32'd2);
    chk("sb_accesses", mon_total - base, 32'd1);
    chk("sb_addr", mon_addr[base[3:0]], 32'h1000);
    chk("sb_wstrb", {28'b0, mon_wstrb[base[3:0]]}, 32'h8);
    chk("sb_wdata", mon_wdata[base[3:0]], 32'hA5000000);
    chk("sb_err", {31'b0, resp_err}, 32'd0);
    chk("sb_rdata", resp_rdata, 32'd0);
    consume();
    chk("sb_mem", mem[14'h0400], 32'hA5000000);

    do_req(1'b0, 32'h2000, 2'd1, 1'b0, 32'h0);
    chk("lhs_latency", lat, 32'd2);
    chk("lhs_rdata", resp_rdata, 32'hFFFFF080);
    chk("lhs_wr", {31'b0, mon_wr[base[3:0]]}, 32'd0);
    chk("lhs_wstrb", {28'b0, mon_wstrb[base[3:0]]}, 32'h0);
    consume();
    do_req(1'b0, 32'h2000, 2'd1, 1'b1, 32'h0);
    chk("lhu_rdata", resp_rdata, 32'h0000F080);
    consume();
    do_req(1'b0, 32'h2001, 2'd0, 1'b0, 32'h0);
    chk("lbs_rdata", resp_rdata, 32'hFFFFFFF0);
    consume();
    do_req(1'b0, 32'h2000, 2'd0, 1'b1, 32'h0);
    chk("lbu_rdata", resp_rdata, 32'h00000080);
    consume();

    do_req(1'b1, 32'h1002, 2'd1, 1'b0, 32'h0000BEEF);
    chk("sh_wstrb", {28'b0, mon_wstrb[base[3:0]]}, 32'hC);
    chk("sh_wdata", mon_wdata[base[3:0]], 32'hBEEF0000);
    consume();
    chk("sh_mem", mem[14'h0400], 32'hBEEF0000);
    do_req(1'b1, 32'h1004, 2'd2, 1'b0, 32'h12345678);
    chk("sw_addr", mon_addr[base[3:0]], 32'h1004);
    chk("sw_wstrb", {28'b0, mon_wstrb[base[3:0]]}, 32'hF);
    consume();
    do_req(1'b0, 32'h1004, 2'd2, 1'b1, 32'h0);
    chk("lw_rdata", resp_rdata, 32'h12345678);
    consume();

    do_req(1'b0, 32'h2000, 2'd3, 1'b0, 32'h0);
    chk("ill_latency", lat, 32'd1);
    chk("ill_accesses", mon_total - base, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("ill_hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("ill_hold_err", {31'b0, resp_err}, 32'd1);
      chk("ill_hold_rdata", resp_rdata, 32'd0);
      chk("ill_hold_req_ready", {31'b0, req_ready}, 32'd0);
      chk("ill_hold_mem_en", {31'b0, mem_en}, 32'd0);
      @(negedge clock);
    end
    consume();

`ifdef LSU_MISALIGN_EN
    do_req(1'b0, 32'h3002, 2'd2, 1'b0, 32'h0);
    chk("lwx_latency", lat, 32'd3);
    chk("lwx_accesses", mon_total - base, 32'd2);
    chk("lwx_addr_lo", mon_addr[base[3:0]], 32'h3000);
    chk("lwx_addr_hi", mon_addr[4'(base + 1)], 32'h3004);
    chk("lwx_rdata", resp_rdata, 32'h66554433);
    consume();
    do_req(1'b1, 32'h3003, 2'd2, 1'b0, 32'hDDCCBBAA);
    chk("swx_wstrb_lo", {28'b0, mon_wstrb[base[3:0]]}, 32'h8);
    chk("swx_wdata_lo", mon_wdata[base[3:0]], 32'hAA000000);
    chk("swx_wstrb_hi", {28'b0, mon_wstrb[4'(base + 1)]}, 32'h7);
    chk("swx_wdata_hi", mon_wdata[4'(base + 1)], 32'h00DDCCBB);
    consume();
    @(negedge clock);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h3002; req_size = 2'd2;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 chk("rsthi_addr", mem_addr, 32'h3004);
`else
    do_req(1'b0, 32'h2001, 2'd1, 1'b0, 32'h0);
    chk("mis_latency", lat, 32'd1);
    chk("mis_err", {31'b0, resp_err}, 32'd1);
    chk("mis_rdata", resp_rdata, 32'd0);
    chk("mis_accesses", mon_total - base, 32'd0);
    consume();
    @(negedge clock);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h1004; req_size = 2'd2;
    @(posedge clock);
    #1 req_valid = 1'b0;
    chk("rstlo_mem_en", {31'b0, mem_en}, 32'd1);
`endif
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mid_mem_en", {31'b0, mem_en}, 32'd0);
    repeat (2) @(negedge clock);
    chk("rst_mid_stays_idle", {31'b0, resp_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
